// File: rtl/cp0_core.sv
// ---------------------------------------------------------------------------
// cp0_core -- MIPS-style coprocessor-0 register file with timer, interrupt
// request generation and exception/ERET bookkeeping for a dual-issue pipe.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   we_i/waddr_i/wsel_i/data_i MTC0 write port (register number, select, data)
//   raddr_i/rsel_i             MFC0 read address; data_o is combinational
//   int_i                      level-sensitive external interrupt lines
//   exc_flag_i/exc_code_i/exc_slot_i  exception commit, ExcCode, issuing slot
//   pc1_i/pc2_i/bd1_i/bd2_i    per-slot PC and branch-delay-slot flag
//   badvaddr_i                 faulting address for AdEL/AdES
//   eret_i                     ERET commit
//   status_o/cause_o/epc_o/ebase_o  live register images
//   timer_int_o                Count/Compare interrupt pending
//   int_req_o                  registered interrupt request to the pipeline
//
// Read-only BadVAddr, PRId and Config are not writable through MTC0. The
// fixed EBase[31:30] field is always 2'b10, so RESET_EBASE[31:30] should be
// 2'b10 as well.
// ---------------------------------------------------------------------------
module cp0_core #(
    parameter int          HW_INT_NUM  = 6,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] RESET_EBASE = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [2:0]            wsel_i,
    input  logic [31:0]           data_i,
    input  logic [4:0]            raddr_i,
    input  logic [2:0]            rsel_i,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_flag_i,
    input  logic [4:0]            exc_code_i,
    input  logic                  exc_slot_i,
    input  logic [31:0]           pc1_i,
    input  logic [31:0]           pc2_i,
    input  logic                  bd1_i,
    input  logic                  bd2_i,
    input  logic [31:0]           badvaddr_i,
    input  logic                  eret_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           ebase_o,
    output logic                  timer_int_o,
    output logic                  int_req_o
);

    // Register keys are {register number, select}.
    localparam logic [7:0] KEY_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] KEY_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] KEY_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] KEY_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] KEY_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] KEY_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] KEY_PRID     = {5'd15, 3'd0};
    localparam logic [7:0] KEY_CONFIG   = {5'd16, 3'd0};
    localparam logic [7:0] KEY_EBASE    = {5'd15, 3'd1};

    localparam logic [31:0] PRID_VALUE   = 32'h0001_8003;
    localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

    // Architectural state
    logic [3:0]  presc_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        cmp_armed_r;
    logic        timer_int_r;
    logic [31:0] badvaddr_r;
    logic [31:0] epc_r;
    logic [7:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [4:0]  exc_code_r;
    logic [5:0]  hw_ip_r;      // sampled int_i, Cause.IP[7:2] before timer OR
    logic [1:0]  sw_ip_r;      // software interrupts, Cause.IP[1:0]
    logic [17:0] ebase_r;      // EBase[29:12]
    logic        int_req_r;

    // Decoded write strobes and helper combinational values
    logic [7:0]  wr_key_s;
    logic [7:0]  rd_key_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        wr_cause_s;
    logic        wr_epc_s;
    logic        wr_ebase_s;
    logic [5:0]  int_ext_s;
    logic [31:0] victim_pc_s;
    logic        victim_bd_s;
    logic [31:0] epc_cand_s;
    logic        epc_capture_s;
    logic        count_match_s;
    logic [7:0]  cause_ip_s;
    logic        int_pending_s;
    logic [31:0] rdata_s;

    assign wr_key_s = {waddr_i, wsel_i};
    assign rd_key_s = {raddr_i, rsel_i};

    assign wr_count_s   = we_i && (wr_key_s == KEY_COUNT);
    assign wr_compare_s = we_i && (wr_key_s == KEY_COMPARE);
    assign wr_status_s  = we_i && (wr_key_s == KEY_STATUS);
    assign wr_cause_s   = we_i && (wr_key_s == KEY_CAUSE);
    assign wr_epc_s     = we_i && (wr_key_s == KEY_EPC);
    assign wr_ebase_s   = we_i && (wr_key_s == KEY_EBASE);

    // Lines above HW_INT_NUM are tied to zero.
    assign int_ext_s = 6'(int_i);

    // EPC/BD are only captured by the first exception of a nest.
    assign epc_capture_s = exc_flag_i && !exl_r;

    // Exception victim selection and EPC candidate.
    always_comb begin
        victim_pc_s = pc1_i;
        victim_bd_s = bd1_i;
        if (exc_slot_i) begin
            victim_pc_s = pc2_i;
            victim_bd_s = bd2_i;
        end else begin
            victim_pc_s = pc1_i;
            victim_bd_s = bd1_i;
        end
        if (victim_bd_s) begin
            epc_cand_s = victim_pc_s - 32'd4;
        end else begin
            epc_cand_s = victim_pc_s;
        end
    end

    // Timer match is only meaningful once software has programmed Compare.
    assign count_match_s = cmp_armed_r && (count_r == compare_r);

    // IP[7] is shared between hardware line 5 and the timer.
    assign cause_ip_s    = {hw_ip_r[5] | timer_int_r, hw_ip_r[4:0], sw_ip_r};
    assign int_pending_s = ie_r & ~exl_r & (|(im_r & cause_ip_s));

    assign status_o    = {9'd0, 1'b1, 6'd0, im_r, 6'd0, exl_r, ie_r};
    assign cause_o     = {bd_r, timer_int_r, 14'd0, cause_ip_s, 1'b0, exc_code_r, 2'd0};
    assign epc_o       = epc_r;
    assign ebase_o     = {2'b10, ebase_r, 12'd0};
    assign timer_int_o = timer_int_r;
    assign int_req_o   = int_req_r;

    // MFC0 read mux; shows pre-edge register values.
    always_comb begin
        rdata_s = 32'd0;
        case (rd_key_s)
            KEY_BADVADDR: rdata_s = badvaddr_r;
            KEY_COUNT:    rdata_s = count_r;
            KEY_COMPARE:  rdata_s = compare_r;
            KEY_STATUS:   rdata_s = status_o;
            KEY_CAUSE:    rdata_s = cause_o;
            KEY_EPC:      rdata_s = epc_r;
            KEY_PRID:     rdata_s = PRID_VALUE;
            KEY_CONFIG:   rdata_s = CONFIG_VALUE;
            KEY_EBASE:    rdata_s = ebase_o;
            default:      rdata_s = 32'd0;
        endcase
    end

    assign data_o = rdata_s;

    // Prescaler and Count; an MTC0 Count restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 4'd0;
            count_r <= 32'd0;
        end else if (wr_count_s) begin
            presc_r <= 4'd0;
            count_r <= data_i;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= 4'd0;
            count_r <= count_r + 32'd1;
        end else begin
            presc_r <= presc_r + 4'd1;
        end
    end

    // Compare, arming flag and sticky timer interrupt; a Compare write
    // acknowledges the interrupt and beats a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_r   <= 32'd0;
            cmp_armed_r <= 1'b0;
            timer_int_r <= 1'b0;
        end else if (wr_compare_s) begin
            compare_r   <= data_i;
            cmp_armed_r <= 1'b1;
            timer_int_r <= 1'b0;
        end else if (count_match_s) begin
            timer_int_r <= 1'b1;
        end
    end

    // BadVAddr is captured only for address-error exceptions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_r <= 32'd0;
        end else if (exc_flag_i && ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES))) begin
            badvaddr_r <= badvaddr_i;
        end
    end

    // EPC and Cause.BD; hardware capture beats a same-cycle MTC0 EPC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_r <= 32'd0;
            bd_r  <= 1'b0;
        end else if (epc_capture_s) begin
            epc_r <= epc_cand_s;
            bd_r  <= victim_bd_s;
        end else if (wr_epc_s) begin
            epc_r <= data_i;
        end
    end

    // Status.IM/IE from MTC0; EXL is owned by exception/ERET when they fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_r  <= 8'd0;
            ie_r  <= 1'b0;
            exl_r <= 1'b0;
        end else begin
            if (wr_status_s) begin
                im_r <= data_i[15:8];
                ie_r <= data_i[0];
            end
            if (exc_flag_i) begin
                exl_r <= 1'b1;
            end else if (eret_i) begin
                exl_r <= 1'b0;
            end else if (wr_status_s) begin
                exl_r <= data_i[1];
            end
        end
    end

    // Cause: ExcCode from exceptions, software IP from MTC0, hardware IP
    // resampled every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_code_r <= 5'd0;
            sw_ip_r    <= 2'd0;
            hw_ip_r    <= 6'd0;
        end else begin
            hw_ip_r <= int_ext_s;
            if (exc_flag_i) begin
                exc_code_r <= exc_code_i;
            end
            if (wr_cause_s) begin
                sw_ip_r <= data_i[9:8];
            end
        end
    end

    // EBase programmable field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ebase_r <= RESET_EBASE[29:12];
        end else if (wr_ebase_s) begin
            ebase_r <= data_i[29:12];
        end
    end

    // Registered interrupt request, one cycle behind the register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_req_r <= 1'b0;
        end else begin
            int_req_r <= int_pending_s;
        end
    end

endmodule

// File: tb/tb_cp0_core.sv
module tb_cp0_core;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'd0;
    logic [2:0]  wsel_i = 3'd0;
    logic [31:0] data_i = 32'd0;
    logic [4:0]  raddr_i = 5'd0;
    logic [2:0]  rsel_i = 3'd0;
    logic [5:0]  int_i = 6'd0;
    logic        exc_flag_i = 1'b0;
    logic [4:0]  exc_code_i = 5'd0;
    logic        exc_slot_i = 1'b0;
    logic [31:0] pc1_i = 32'd0;
    logic [31:0] pc2_i = 32'd0;
    logic        bd1_i = 1'b0;
    logic        bd2_i = 1'b0;
    logic [31:0] badvaddr_i = 32'd0;
    logic        eret_i = 1'b0;
    logic [31:0] data_o, status_o, cause_o, epc_o, ebase_o;
    logic        timer_int_o, int_req_o;

    always #5 clk = ~clk;

    cp0_core #(.HW_INT_NUM(6), .COUNT_DIV(DIV), .RESET_EBASE(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i),
        .data_i(data_i), .raddr_i(raddr_i), .rsel_i(rsel_i), .int_i(int_i),
        .exc_flag_i(exc_flag_i), .exc_code_i(exc_code_i), .exc_slot_i(exc_slot_i),
        .pc1_i(pc1_i), .pc2_i(pc2_i), .bd1_i(bd1_i), .bd2_i(bd2_i),
        .badvaddr_i(badvaddr_i), .eret_i(eret_i), .data_o(data_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
        .timer_int_o(timer_int_o), .int_req_o(int_req_o)
    );

    int nvec = 0;
    int nerr = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Count is kept as "value at last load" plus elapsed cycles.
    logic [31:0] m_base;
    int unsigned m_cyc;
    logic [31:0] m_compare, m_badv, m_epc, m_status, m_ebase;
    logic        m_armed, m_timer, m_bd, m_intreq;
    logic [4:0]  m_code;
    logic [1:0]  m_sw;
    logic [5:0]  m_ints;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / DIV);
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = 32'd0;
        c[31]    = m_bd;
        c[30]    = m_timer;
        c[15:10] = m_ints;
        c[15]    = m_ints[5] | m_timer;
        c[9:8]   = m_sw;
        c[6:2]   = m_code;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s == 3'd1 && a == 5'd15) return m_ebase;
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h0001_8003;
            5'd16:   return 32'h0000_8000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_base = 32'd0; m_cyc = 0; m_compare = 32'd0; m_badv = 32'd0; m_epc = 32'd0;
        m_status = 32'h0040_0000; m_ebase = 32'h8000_0000; m_armed = 1'b0;
        m_timer = 1'b0; m_bd = 1'b0; m_intreq = 1'b0; m_code = 5'd0; m_sw = 2'd0;
        m_ints = 6'd0;
    endtask

    task automatic model_step();
        logic [31:0] cnt, cause, pc;
        logic        old_exl, next_req, hit, b;
        logic [7:0]  key;
        cnt      = m_count();
        cause    = m_cause();
        old_exl  = m_status[1];
        next_req = m_status[0] & ~m_status[1] & (|(m_status[15:8] & cause[15:8]));
        hit      = m_armed && (cnt == m_compare);
        key      = {waddr_i, wsel_i};
        // timer
        if (we_i && key == {5'd11, 3'd0}) begin
            m_compare = data_i; m_armed = 1'b1; m_timer = 1'b0;
        end else if (hit) begin
            m_timer = 1'b1;
        end
        // count
        if (we_i && key == {5'd9, 3'd0}) begin
            m_base = data_i; m_cyc = 0;
        end else begin
            m_cyc++;
        end
        // software writes
        if (we_i && key == {5'd12, 3'd0}) m_status = 32'h0040_0000 | (data_i & 32'h0000_FF03);
        if (we_i && key == {5'd13, 3'd0}) m_sw = data_i[9:8];
        if (we_i && key == {5'd14, 3'd0}) m_epc = data_i;
        if (we_i && key == {5'd15, 3'd1}) m_ebase = 32'h8000_0000 | (data_i & 32'h3FFF_F000);
        // hardware events override software writes to the same fields
        if (exc_flag_i) begin
            m_code = exc_code_i;
            if (!old_exl) begin
                pc = exc_slot_i ? pc2_i : pc1_i;
                b  = exc_slot_i ? bd2_i : bd1_i;
                m_epc = b ? pc - 32'd4 : pc;
                m_bd  = b;
            end
            m_status[1] = 1'b1;
            if (exc_code_i == 5'd4 || exc_code_i == 5'd5) m_badv = badvaddr_i;
        end else if (eret_i) begin
            m_status[1] = 1'b0;
        end
        m_ints   = int_i;
        m_intreq = next_req;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare process: outputs vs model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("data_o",      data_o,      m_read(raddr_i, rsel_i));
            chk("status_o",    status_o,    m_status);
            chk("cause_o",     cause_o,     m_cause());
            chk("epc_o",       epc_o,       m_epc);
            chk("ebase_o",     ebase_o,     m_ebase);
            chk("timer_int_o", {31'd0, timer_int_o}, {31'd0, m_timer});
            chk("int_req_o",   {31'd0, int_req_o},   {31'd0, m_intreq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wsel_i = s; data_i = d;
        cyc();
        we_i = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] regs [8];
        int i;
        regs[0] = 5'd8;  regs[1] = 5'd9;  regs[2] = 5'd11; regs[3] = 5'd12;
        regs[4] = 5'd13; regs[5] = 5'd14; regs[6] = 5'd15; regs[7] = 5'd16;
        i = int'($urandom_range(0, 8));
        if (i == 8) return 5'($urandom);
        return regs[i];
    endfunction

    logic [31:0] exp034 [4];

    initial begin
        exp034[0] = 32'd0; exp034[1] = 32'd1; exp034[2] = 32'd1; exp034[3] = 32'd2;

        // reset values
        #1 rst = 1'b1;
        #1 check_en = 1'b1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause",  cause_o,  32'd0);
        chk("rst_epc",    epc_o,    32'd0);
        chk("rst_ebase",  ebase_o,  32'h8000_0000);
        chk("rst_timer",  {31'd0, timer_int_o}, 32'd0);
        chk("rst_intreq", {31'd0, int_req_o},   32'd0);

        // Count sequence after reset release
        @(posedge clk); #1;
        rst = 1'b0; raddr_i = 5'd9; rsel_i = 3'd0;
        #1 chk("count_seq0", data_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("count_seq", data_o, exp034[i]);
        end
        chk("timer_cmp0", {31'd0, timer_int_o}, 32'd0);

        // timer: Compare=5, Count=3
        wr(5'd11, 3'd0, 32'd5);
        wr(5'd9,  3'd0, 32'd3);
        repeat (4) cyc();
        chk("timer_early", {31'd0, timer_int_o}, 32'd0);
        chk("count_at5",   data_o, 32'd5);
        cyc();
        chk("timer_set",   {31'd0, timer_int_o}, 32'd1);
        chk("cause_ti",    {31'd0, cause_o[30]}, 32'd1);
        chk("cause_ip7",   {31'd0, cause_o[15]}, 32'd1);
        wr(5'd11, 3'd0, 32'd100);
        chk("timer_clr",   {31'd0, timer_int_o}, 32'd0);

        // interrupt request latency
        wr(5'd12, 3'd0, 32'h0000_0401);
        int_i = 6'd1;
        cyc();
        chk("intreq_1edge", {31'd0, int_req_o}, 32'd0);
        cyc();
        chk("intreq_2edge", {31'd0, int_req_o}, 32'd1);
        wr(5'd12, 3'd0, 32'h0000_0403);
        cyc();
        chk("intreq_exl",   {31'd0, int_req_o}, 32'd0);
        int_i = 6'd0;
        wr(5'd12, 3'd0, 32'd0);

        // AdEL in slot 2 delay slot
        exc_flag_i = 1'b1; exc_code_i = 5'd4; exc_slot_i = 1'b1;
        pc1_i = 32'h0000_1000; bd1_i = 1'b0; pc2_i = 32'hBFC0_0104; bd2_i = 1'b1;
        badvaddr_i = 32'h0000_0001; raddr_i = 5'd8;
        cyc();
        exc_flag_i = 1'b0;
        chk("exc_epc",   epc_o, 32'hBFC0_0100);
        chk("exc_bd",    {31'd0, cause_o[31]}, 32'd1);
        chk("exc_code",  {27'd0, cause_o[6:2]}, 32'd4);
        chk("exc_badv",  data_o, 32'h0000_0001);
        chk("exc_exl",   {31'd0, status_o[1]}, 32'd1);

        // nested exception, then ERET
        exc_flag_i = 1'b1; exc_code_i = 5'd8; exc_slot_i = 1'b0;
        pc1_i = 32'h0000_1234; bd1_i = 1'b0; badvaddr_i = 32'hDEAD_BEEF;
        cyc();
        exc_flag_i = 1'b0;
        chk("nest_code", {27'd0, cause_o[6:2]}, 32'd8);
        chk("nest_epc",  epc_o, 32'hBFC0_0100);
        chk("nest_bd",   {31'd0, cause_o[31]}, 32'd1);
        chk("nest_badv", data_o, 32'h0000_0001);
        eret_i = 1'b1;
        cyc();
        eret_i = 1'b0;
        chk("eret_exl",  {31'd0, status_o[1]}, 32'd0);

        // exception vs same-cycle MTC0 Status
        we_i = 1'b1; waddr_i = 5'd12; wsel_i = 3'd0; data_i = 32'h0000_FF01;
        exc_flag_i = 1'b1; exc_code_i = 5'd10; exc_slot_i = 1'b0;
        pc1_i = 32'h0000_2000; bd1_i = 1'b0;
        cyc();
        we_i = 1'b0; exc_flag_i = 1'b0;
        chk("coll_status", status_o, 32'h0040_FF03);
        chk("coll_epc",    epc_o,    32'h0000_2000);
        // ERET vs same-cycle MTC0 Status setting EXL
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_0003; eret_i = 1'b1;
        cyc();
        we_i = 1'b0; eret_i = 1'b0;
        chk("eret_coll", status_o, 32'h0040_0001);
        // exception beats ERET
        exc_flag_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'd0;
        cyc();
        exc_flag_i = 1'b0; eret_i = 1'b0;
        chk("exc_over_eret", {31'd0, status_o[1]}, 32'd1);
        wr(5'd12, 3'd0, 32'd0);

        // Count wrap
        raddr_i = 5'd9;
        wr(5'd9, 3'd0, 32'hFFFF_FFFF);
        chk("wrap_load", data_o, 32'hFFFF_FFFF);
        cyc();
        chk("wrap_hold", data_o, 32'hFFFF_FFFF);
        cyc();
        chk("wrap_zero", data_o, 32'd0);

        // EBase, Cause software bits, constant registers
        wr(5'd15, 3'd1, 32'hFFFF_FFFF);
        chk("ebase_wr", ebase_o, 32'hBFFF_F000);
        wr(5'd13, 3'd0, 32'hFFFF_FFFF);
        chk("cause_sw",  {30'd0, cause_o[9:8]}, 32'd3);
        chk("cause_hi0", {18'd0, cause_o[29:16]}, 32'd0);
        raddr_i = 5'd15; rsel_i = 3'd0;
        #1 chk("prid", data_o, 32'h0001_8003);
        raddr_i = 5'd16;
        #1 chk("config", data_o, 32'h0000_8000);
        raddr_i = 5'd17;
        #1 chk("unmapped", data_o, 32'd0);

        // arm timer, then asynchronous reset mid-cycle
        raddr_i = 5'd9;
        wr(5'd11, 3'd0, 32'd52);
        wr(5'd9,  3'd0, 32'd52);
        cyc();
        chk("timer_pre_rst", {31'd0, timer_int_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_cause",  cause_o,  32'd0);
        chk("arst_epc",    epc_o,    32'd0);
        chk("arst_ebase",  ebase_o,  32'h8000_0000);
        chk("arst_timer",  {31'd0, timer_int_o}, 32'd0);
        chk("arst_intreq", {31'd0, int_req_o},   32'd0);
        chk("arst_count",  data_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // randomized phase
        for (int n = 0; n < 4000; n++) begin
            we_i    = ($urandom_range(0, 3) == 0);
            waddr_i = pick_reg();
            wsel_i  = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                      ((waddr_i == 5'd15 && $urandom_range(0, 1) == 1) ? 3'd1 : 3'd0);
            data_i  = $urandom;
            if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
                data_i = m_count() + 32'($urandom_range(0, 6));
            raddr_i = pick_reg();
            rsel_i  = (raddr_i == 5'd15 && $urandom_range(0, 1) == 1) ? 3'd1 : 3'd0;
            if ($urandom_range(0, 7) == 0) int_i = 6'($urandom);
            exc_flag_i = ($urandom_range(0, 11) == 0);
            exc_code_i = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            exc_slot_i = 1'($urandom);
            pc1_i = $urandom; pc2_i = $urandom;
            bd1_i = 1'($urandom); bd2_i = 1'($urandom);
            badvaddr_i = $urandom;
            eret_i = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 799) == 0);
            cyc();
        end
        rst = 1'b0; we_i = 1'b0; exc_flag_i = 1'b0; eret_i = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
